// File: rtl/ex_muldiv_seq_if.sv
// EX-stage <-> RV32M sequencer handshake: op issue, flush, stall and result return.
interface ex_muldiv_seq_if #(parameter int XLEN = 32);
  logic            start_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  logic [4:0]      rd_i;
  logic            flush_i;
  logic            stall_o;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_o;

  modport master (
    output start_i, funct3_i, op1_i, op2_i, rd_i, flush_i,
    input  stall_o, busy_o, done_o, result_o, rd_o
  );

  modport slave (
    input  start_i, funct3_i, op1_i, op2_i, rd_i, flush_i,
    output stall_o, busy_o, done_o, result_o, rd_o
  );
endinterface

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiply or restoring divide on magnitudes,
// sign fix-up at the end, single-cycle fast paths for divide-by-zero and signed overflow.
module ex_muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  ex_muldiv_seq_if.slave bus
);
  localparam int W = XLEN;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  typedef struct packed {
    logic [2:0] f3;
    logic [4:0] rd;
    logic       neg;
  } op_t;

  state_e       state_q;
  logic [4:0]   cnt_q;
  op_t          op_q;
  logic [W-1:0] mcd_q;      // multiplicand or divisor magnitude
  logic [2*W-1:0] acc_q;    // mul: {hi, lo/multiplier}; div: {remainder, dividend/quotient}
  logic [W-1:0] result_q;
  logic [4:0]   rdo_q;
  logic         done_q;
  logic         busy_q;

  // issue-side decode
  logic [2:0]   f3;
  logic         is_div, s1, s2, n1, n2, neg_in, div0, ovf, fast;
  logic [W-1:0] m1, m2, fast_res;

  always_comb begin
    f3     = bus.funct3_i;
    is_div = f3[2];
    s1     = (f3 != 3'd3) && (f3 != 3'd5) && (f3 != 3'd7);
    s2     = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd6);
    n1     = s1 & bus.op1_i[W-1];
    n2     = s2 & bus.op2_i[W-1];
    m1     = n1 ? (~bus.op1_i + 1'b1) : bus.op1_i;
    m2     = n2 ? (~bus.op2_i + 1'b1) : bus.op2_i;
    // REM takes the dividend sign; everything else the product/quotient sign
    neg_in = (is_div && f3[1]) ? n1 : (n1 ^ n2);
    div0   = is_div && (bus.op2_i == '0);
    ovf    = is_div && !f3[0] && (bus.op1_i == {1'b1, {(W-1){1'b0}}}) && (bus.op2_i == '1);
    fast   = div0 || ovf;
    if (div0) fast_res = f3[1] ? bus.op1_i : '1;
    else      fast_res = f3[1] ? '0 : {1'b1, {(W-1){1'b0}}};
  end

  // one iteration step for each datapath
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_nxt, div_nxt;
  logic           ge;
  logic [W-1:0]   r_sub;

  always_comb begin
    mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcd_q} : {(W+1){1'b0}});
    mul_nxt = {mul_sum, acc_q[W-1:1]};
    // trial subtract of {rem, next dividend bit}; the remainder fits in W bits whenever it succeeds
    ge      = acc_q[2*W-1:W-1] >= {1'b0, mcd_q};
    r_sub   = acc_q[2*W-2:W-1] - mcd_q;
    div_nxt = {(ge ? r_sub : acc_q[2*W-2:W-1]), acc_q[W-2:0], ge};
  end

  // sign fix-up and field select
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix, fix_res;

  always_comb begin
    prod_fix = op_q.neg ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = op_q.neg ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0];
    rem_fix  = op_q.neg ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];
    case (op_q.f3)
      3'd0:             fix_res = prod_fix[W-1:0];
      3'd1, 3'd2, 3'd3: fix_res = prod_fix[2*W-1:W];
      3'd4, 3'd5:       fix_res = quo_fix;
      default:          fix_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      mcd_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      rdo_q    <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_i && !bus.flush_i) begin
            op_q   <= '{f3: f3, rd: bus.rd_i, neg: neg_in};
            cnt_q  <= 5'd31;
            busy_q <= 1'b1;
            if (fast) begin
              result_q <= fast_res;
              rdo_q    <= bus.rd_i;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              mcd_q   <= is_div ? m2 : m1;
              acc_q   <= {{W{1'b0}}, (is_div ? m1 : m2)};
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.flush_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= op_q.f3[2] ? div_nxt : mul_nxt;
            cnt_q <= cnt_q - 5'd1;
            if (cnt_q == 5'd0) state_q <= FIX;
          end
        end
        FIX: begin
          if (bus.flush_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            result_q <= fix_res;
            rdo_q    <= op_q.rd;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // reset is folded in so a held start_i cannot stall a pipeline that is being reset
  assign bus.stall_o  = reset_ni & (((state_q == IDLE) & bus.start_i & ~bus.flush_i) |
                                    (state_q == CALC) | (state_q == FIX));
  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;
  assign bus.rd_o     = rdo_q;
endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed and random RV32M ops against an arithmetic reference model; checks result, rd and timing.
module tb_ex_muldiv_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_muldiv_seq_if #(.XLEN(32)) bus();
  ex_muldiv_seq #(.XLEN(32)) dut (.clk_i(clk), .reset_ni(rst_n), .bus(bus.slave));

  int total = 0;
  int bad = 0;
  logic [31:0] last_exp = '0;
  logic [4:0]  last_rd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'h0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op; optionally drive a stray start_i at cycle N+inj while the op is busy.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input string tag, input int inj);
    int k, stalls, el, extra;
    bit seen;
    logic [31:0] exp;
    exp = ref_res(f3, a, b);
    el  = lat(f3, a, b);
    @(negedge clk);
    bus.start_i = 1'b1; bus.funct3_i = f3; bus.op1_i = a; bus.op2_i = b; bus.rd_i = rd;
    #1 chk({tag, ".stall_issue"}, {31'b0, bus.stall_o}, 32'd1);
    @(negedge clk);
    bus.start_i = 1'b0; bus.op1_i = $urandom; bus.op2_i = $urandom; bus.rd_i = 5'($urandom);
    bus.funct3_i = 3'($urandom);
    k = 1; stalls = 0; seen = 0;
    while (k <= 60 && !seen) begin
      if (bus.done_o) begin
        seen = 1;
      end else begin
        if (bus.stall_o) stalls++;
        bus.start_i = (k == inj);
        @(negedge clk);
        k++;
      end
    end
    bus.start_i = 1'b0;
    chk({tag, ".done_seen"}, {31'b0, seen}, 32'd1);
    chk({tag, ".latency"}, k, el);
    chk({tag, ".result"}, bus.result_o, exp);
    chk({tag, ".rd"}, {27'b0, bus.rd_o}, {27'b0, rd});
    chk({tag, ".stall_cycles"}, stalls, el - 1);
    chk({tag, ".stall_done"}, {31'b0, bus.stall_o}, 32'd0);
    @(negedge clk);
    chk({tag, ".done_pulse"}, {31'b0, bus.done_o}, 32'd0);
    chk({tag, ".result_hold"}, bus.result_o, exp);
    last_exp = exp;
    last_rd  = rd;
    if (inj > 0) begin
      extra = 0;
      for (int i = 0; i < 40; i++) begin
        if (bus.done_o) extra++;
        @(negedge clk);
      end
      chk({tag, ".extra_done"}, extra, 0);
    end
  endtask

  initial begin
    int dones;
    bus.start_i = 1'b0; bus.funct3_i = '0; bus.op1_i = '0; bus.op2_i = '0;
    bus.rd_i = '0; bus.flush_i = 1'b0;
    #1;
    chk("rst.busy", {31'b0, bus.busy_o}, 32'd0);
    chk("rst.done", {31'b0, bus.done_o}, 32'd0);
    chk("rst.stall", {31'b0, bus.stall_o}, 32'd0);
    chk("rst.result", bus.result_o, 32'd0);
    chk("rst.rd", {27'b0, bus.rd_o}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, "mul", 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, "mulh", 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, "mulhu", 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd8, "mulhsu", 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, "div", 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, "rem", 0);
    run_op(3'd5, 32'd100, 32'd7, 5'd11, "divu", 0);
    run_op(3'd7, 32'd100, 32'd7, 5'd12, "remu", 0);
    run_op(3'd4, 32'd5, 32'd0, 5'd13, "div0", 0);
    run_op(3'd6, 32'd5, 32'd0, 5'd14, "rem0", 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, "divovf", 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, "removf", 0);

    // flush at N+10 of a DIVU
    @(negedge clk);
    bus.start_i = 1'b1; bus.funct3_i = 3'd5; bus.op1_i = 32'd1000; bus.op2_i = 32'd3; bus.rd_i = 5'd20;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    chk("flush.busy", {31'b0, bus.busy_o}, 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done_o) dones++;
      @(negedge clk);
    end
    chk("flush.no_done", dones, 0);
    chk("flush.result_kept", bus.result_o, last_exp);
    chk("flush.rd_kept", {27'b0, bus.rd_o}, {27'b0, last_rd});

    run_op(3'd5, 32'd12345, 32'd17, 5'd21, "ignore_start", 5);

    // asynchronous reset mid-CALC
    @(negedge clk);
    bus.start_i = 1'b1; bus.funct3_i = 3'd0; bus.op1_i = 32'd9; bus.op2_i = 32'd9; bus.rd_i = 5'd3;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.busy", {31'b0, bus.busy_o}, 32'd0);
    chk("arst.done", {31'b0, bus.done_o}, 32'd0);
    chk("arst.stall", {31'b0, bus.stall_o}, 32'd0);
    chk("arst.result", bus.result_o, 32'd0);
    chk("arst.rd", {27'b0, bus.rd_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd0, 32'd3, 32'd4, 5'd4, "post_rst_mul", 0);

    for (int i = 0; i < 40; i++)
      run_op(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom), "rand", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
